// File: rtl/chip8_timer_bank.sv
// CPU-step and 60 Hz strobe generator plus a bank of CHIP-8 down-counters
// (channel 0 = delay timer, channel 1 = sound timer) with a select/data port.
module chip8_timer_bank #(
    parameter int CLK_HZ   = 12000000,
    parameter int CPU_HZ   = 500,
    parameter int TICK_HZ  = 60,
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 8,
    parameter int SEL_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                timer_cpu_tick,
    output logic                timer_60hz_tick,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    wr_sel,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [WIDTH-1:0]    rd_data,
    output logic [CHANNELS-1:0] active
);

    localparam int CPU_DIV  = CLK_HZ / CPU_HZ;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int CPU_W    = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CPU_W-1:0]  CPU_LAST  = CPU_W'(CPU_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    if (CPU_DIV < 2) begin : g_cpu_div_check
        $error("chip8_timer_bank: CLK_HZ/CPU_HZ must be >= 2");
    end
    if (TICK_DIV < 2) begin : g_tick_div_check
        $error("chip8_timer_bank: CLK_HZ/TICK_HZ must be >= 2");
    end
    if ((CHANNELS < 1) || (CHANNELS > 16)) begin : g_channels_check
        $error("chip8_timer_bank: CHANNELS must be 1..16");
    end
    if ((64'd1 << SEL_W) < 64'(CHANNELS)) begin : g_sel_w_check
        $error("chip8_timer_bank: SEL_W too narrow for CHANNELS");
    end

    logic [CPU_W-1:0]  cpu_cnt_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic              cpu_wrap_s;
    logic              tick_wrap_s;
    logic [WIDTH-1:0]  chan_r [CHANNELS];
    logic [WIDTH-1:0]  rd_next_s;

    // A wrap only happens on a running edge; the same condition drives the strobes.
    assign cpu_wrap_s  = run && (cpu_cnt_r == CPU_LAST);
    assign tick_wrap_s = run && (tick_cnt_r == TICK_LAST);

    // CPU step divider and its registered strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_cnt_r      <= {CPU_W{1'b0}};
            timer_cpu_tick <= 1'b0;
        end else if (run) begin
            cpu_cnt_r      <= cpu_wrap_s ? {CPU_W{1'b0}} : cpu_cnt_r + CPU_W'(1);
            timer_cpu_tick <= cpu_wrap_s;
        end else begin
            timer_cpu_tick <= 1'b0;
        end
    end

    // 60 Hz divider and its registered strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_r      <= {TICK_W{1'b0}};
            timer_60hz_tick <= 1'b0;
        end else if (run) begin
            tick_cnt_r      <= tick_wrap_s ? {TICK_W{1'b0}} : tick_cnt_r + TICK_W'(1);
            timer_60hz_tick <= tick_wrap_s;
        end else begin
            timer_60hz_tick <= 1'b0;
        end
    end

    // Channel registers: a CPU load takes priority over the strobe decrement
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                chan_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && (wr_sel == SEL_W'(i))) begin
                    chan_r[i] <= wr_data;
                end else if (tick_wrap_s && (chan_r[i] != {WIDTH{1'b0}})) begin
                    chan_r[i] <= chan_r[i] - WIDTH'(1);
                end
            end
        end
    end

    // Read mux; unmatched selects fall through to zero
    always_comb begin
        rd_next_s = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            rd_next_s = (rd_sel == SEL_W'(i)) ? chan_r[i] : rd_next_s;
        end
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= {WIDTH{1'b0}};
        end else begin
            rd_data <= rd_next_s;
        end
    end

    // Non-zero flags per channel
    always_comb begin
        active = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            active[i] = (chan_r[i] != {WIDTH{1'b0}});
        end
    end

endmodule

// File: tb/tb_chip8_timer_bank.sv
// Self-checking bench for chip8_timer_bank: table-driven cadence vectors,
// a per-cycle scoreboard and hand-written corner-case sequences.
module tb_chip8_timer_bank;

    localparam int CLK_HZ   = 120;
    localparam int CPU_HZ   = 20;
    localparam int TICK_HZ  = 10;
    localparam int CHANNELS = 2;
    localparam int WIDTH    = 8;
    localparam int SEL_W    = 4;
    localparam int CPU_DIV  = 6;
    localparam int TICK_DIV = 12;

    logic                clk;
    logic                reset;
    logic                run;
    logic                timer_cpu_tick;
    logic                timer_60hz_tick;
    logic                wr_en;
    logic [SEL_W-1:0]    wr_sel;
    logic [WIDTH-1:0]    wr_data;
    logic [SEL_W-1:0]    rd_sel;
    logic [WIDTH-1:0]    rd_data;
    logic [CHANNELS-1:0] active;

    chip8_timer_bank #(
        .CLK_HZ(CLK_HZ), .CPU_HZ(CPU_HZ), .TICK_HZ(TICK_HZ),
        .CHANNELS(CHANNELS), .WIDTH(WIDTH), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .reset(reset), .run(run),
        .timer_cpu_tick(timer_cpu_tick), .timer_60hz_tick(timer_60hz_tick),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_sel(rd_sel), .rd_data(rd_data), .active(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       cpu;
        logic       tick;
        logic [7:0] rd;
        logic [1:0] act;
    } exp_t;

    typedef struct {
        logic       run;
        logic       wr_en;
        logic [3:0] wr_sel;
        logic [7:0] wr_data;
        logic [3:0] rd_sel;
        logic       exp_cpu;
        logic       exp_tick;
    } vec_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state, advanced from the inputs as each cycle is driven
    int         m_cpu;
    int         m_tick;
    logic [7:0] m_ch [2];
    logic       cur_run;
    logic [3:0] cur_rd;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic r, input logic we,
                       input logic [3:0] ws, input logic [7:0] wd, input logic [3:0] rs);
        exp_t e;
        exp_t got;
        reset = rst; run = r; wr_en = we; wr_sel = ws; wr_data = wd; rd_sel = rs;
        if (rst) begin
            m_cpu = 0; m_tick = 0; m_ch[0] = 8'h00; m_ch[1] = 8'h00;
            e = '{1'b0, 1'b0, 8'h00, 2'b00};
        end else begin
            e.cpu = 1'b0;
            e.tick = 1'b0;
            if (r) begin
                if (m_cpu == CPU_DIV - 1) begin m_cpu = 0; e.cpu = 1'b1; end
                else m_cpu++;
                if (m_tick == TICK_DIV - 1) begin m_tick = 0; e.tick = 1'b1; end
                else m_tick++;
            end
            e.rd = (rs < 4'd2) ? m_ch[rs[0]] : 8'h00;
            for (int i = 0; i < 2; i++) begin
                if (we && (int'(ws) == i)) m_ch[i] = wd;
                else if (e.tick && (m_ch[i] != 8'h00)) m_ch[i] = m_ch[i] - 8'd1;
            end
            e.act = {m_ch[1] != 8'h00, m_ch[0] != 8'h00};
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("sb_cpu_tick", timer_cpu_tick, got.cpu);
        check("sb_60hz_tick", timer_60hz_tick, got.tick);
        check("sb_rd_data", rd_data, got.rd);
        check("sb_active", active, got.act);
    endtask

    task automatic idle();
        cyc(1'b0, cur_run, 1'b0, 4'd0, 8'h00, cur_rd);
    endtask

    task automatic wait_tick(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * TICK_DIV && !seen; i++) begin
            idle();
            if (timer_60hz_tick === 1'b1) seen = 1'b1;
        end
        check(name, seen, 1'b1);
    endtask

    vec_t tbl [48];

    initial begin
        int cpu_pulses;
        int tick_pulses;
        int freeze_pulses;
        int cpu_gap;
        int tick_gap;

        for (int k = 0; k < 48; k++) begin
            tbl[k] = '{run: 1'b1, wr_en: 1'b0, wr_sel: 4'd0, wr_data: 8'h00, rd_sel: 4'd0,
                       exp_cpu: ((k + 1) % CPU_DIV == 0), exp_tick: ((k + 1) % TICK_DIV == 0)};
        end
        cur_run = 1'b1;
        cur_rd  = 4'd0;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 4'd0);
        check("reset_cpu_tick", timer_cpu_tick, 1'b0);
        check("reset_60hz_tick", timer_60hz_tick, 1'b0);
        check("reset_rd_data", rd_data, 8'h00);
        check("reset_active", active, 2'b00);

        // 1. Divider cadence
        cpu_pulses = 0;
        tick_pulses = 0;
        for (int k = 0; k < 48; k++) begin
            cyc(1'b0, tbl[k].run, tbl[k].wr_en, tbl[k].wr_sel, tbl[k].wr_data, tbl[k].rd_sel);
            check("cadence_cpu", timer_cpu_tick, tbl[k].exp_cpu);
            check("cadence_60hz", timer_60hz_tick, tbl[k].exp_tick);
            if (timer_cpu_tick === 1'b1) cpu_pulses++;
            if (timer_60hz_tick === 1'b1) begin
                tick_pulses++;
                check("cadence_coincide", timer_cpu_tick, 1'b1);
            end
        end
        check("cadence_cpu_count", cpu_pulses, 8);
        check("cadence_60hz_count", tick_pulses, 4);

        // 2. Countdown and saturation on channel 0
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 8'd3, 4'd0);
        idle();
        check("count_rd3", rd_data, 8'd3);
        wait_tick("count_wait1");
        idle();
        check("count_rd2", rd_data, 8'd2);
        wait_tick("count_wait2");
        idle();
        check("count_rd1", rd_data, 8'd1);
        check("count_active_hi", active[0], 1'b1);
        wait_tick("count_wait3");
        check("count_active_lo", active[0], 1'b0);
        idle();
        check("count_rd0", rd_data, 8'd0);
        wait_tick("count_wait4");
        wait_tick("count_wait5");
        idle();
        check("count_sat_rd0", rd_data, 8'd0);

        // 3. Write colliding with the decrement edge
        cyc(1'b0, 1'b1, 1'b1, 4'd1, 8'd5, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 8'd5, 4'd0);
        for (int i = 0; i < TICK_DIV && m_tick != TICK_DIV - 1; i++) idle();
        cyc(1'b0, 1'b1, 1'b1, 4'd1, 8'd9, 4'd1);
        check("collide_strobe", timer_60hz_tick, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 4'd1);
        check("collide_ch1", rd_data, 8'd9);
        cyc(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 4'd0);
        check("collide_ch0", rd_data, 8'd4);

        // 4. run freeze mid-phase (cpu phase 3, tick phase 3 at the freeze)
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 8'd2, 4'd0);
        cur_run = 1'b0;
        freeze_pulses = 0;
        for (int i = 0; i < 30; i++) begin
            idle();
            if (timer_cpu_tick !== 1'b0 || timer_60hz_tick !== 1'b0) freeze_pulses++;
        end
        check("freeze_no_pulses", freeze_pulses, 0);
        check("freeze_ch0", rd_data, 8'd2);
        cur_run = 1'b1;
        cpu_gap = 0;
        tick_gap = 0;
        for (int n = 1; n <= 30 && tick_gap == 0; n++) begin
            idle();
            if (timer_cpu_tick === 1'b1 && cpu_gap == 0) cpu_gap = n;
            if (timer_60hz_tick === 1'b1) tick_gap = n;
        end
        check("resume_cpu_gap", cpu_gap, 3);
        check("resume_60hz_gap", tick_gap, 9);

        // 5. Out-of-range access, with dividers frozen
        cur_run = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 4'd0, 8'h11, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'd1, 8'h22, 4'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'd3, 8'hAA, 4'd3);
        check("oor_rd3", rd_data, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 4'd2, 8'h55, 4'd0);
        check("oor_ch0", rd_data, 8'h11);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 4'd1);
        check("oor_ch1", rd_data, 8'h22);
        check("oor_active", active, 2'b11);

        // 6. Reset mid-operation; a simultaneous write must lose
        cur_run = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 4'd0, 8'd7, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, 4'd1, 8'd4, 4'd0);
        idle();
        idle();
        idle();
        cyc(1'b1, 1'b1, 1'b1, 4'd0, 8'hFF, 4'd0);
        check("rst_mid_cpu", timer_cpu_tick, 1'b0);
        check("rst_mid_60hz", timer_60hz_tick, 1'b0);
        check("rst_mid_rd", rd_data, 8'h00);
        check("rst_mid_active", active, 2'b00);
        cpu_gap = 0;
        tick_gap = 0;
        for (int n = 1; n <= 2 * TICK_DIV && tick_gap == 0; n++) begin
            idle();
            if (timer_cpu_tick === 1'b1 && cpu_gap == 0) cpu_gap = n;
            if (timer_60hz_tick === 1'b1) tick_gap = n;
        end
        check("rst_first_cpu", cpu_gap, CPU_DIV);
        check("rst_first_60hz", tick_gap, TICK_DIV);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
